// File: rtl/spi_controller.sv
// spi_controller
//   SPI initiator for the shared on-chip SPI bus (SPI mode 0, MSB first). A single
//   transfer moves 1 to 4 bytes under a start/busy/done handshake. It runs entirely
//   on sys_clock_i, and every output comes straight from a flop.
//
// Parameters
//   CLK_DIV      SCK half-period in sys_clock_i cycles (4 or more)
//   NUM_CS       number of active-low chip selects (1 to 4)
//
// Ports
//   sys_clock_i  system clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      transfer request, sampled only while idle
//   cs_sel_i     target chip-select index; a start with cs_sel_i >= NUM_CS is ignored
//   len_i        transfer length in bytes minus one
//   tx_data_i    transmit word, right-aligned, captured at start
//   abort_i      (SPI_CONTROLLER_ABORT_EN only) cancel the active transfer
//   rx_data_o    receive word, right-aligned, upper bits zero; updates only at done
//   busy_o       high from the cycle after an accepted start to the end of the gap
//   done_o       one-cycle completion pulse
//   spi_clock_o  SCK, idles low
//   spi_cs_o     active-low chip selects
//   spi_pico_o   controller-out data
//   spi_poci_i   controller-in data
//
// Build option
//   SPI_CONTROLLER_ABORT_EN  adds abort_i. Asserting it during LEAD, LOW, HIGH or TRAIL
//                            drops CS, SCK and PICO on the next edge and moves the FSM
//                            to GAP. There is no done pulse and rx_data_o is kept.

module spi_controller #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned NUM_CS  = 3
) (
    input  logic              sys_clock_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        cs_sel_i,
    input  logic [1:0]        len_i,
    input  logic [31:0]       tx_data_i,
`ifdef SPI_CONTROLLER_ABORT_EN
    input  logic              abort_i,
`endif
    output logic [31:0]       rx_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              spi_clock_o,
    output logic [NUM_CS-1:0] spi_cs_o,
    output logic              spi_pico_o,
    input  logic              spi_poci_i
);

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StLow,
        StHigh,
        StTrail,
        StGap
    } state_e;

    localparam int unsigned    CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    // Sequencing state
    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [4:0]        bit_q, bit_d;      // index of the tx bit currently on PICO
    logic [1:0]        len_q, len_d;
    logic [1:0]        cs_sel_q, cs_sel_d;
    logic [31:0]       tx_q, tx_d;
    logic [31:0]       rx_sr_q, rx_sr_d;

    // Registered outputs
    logic [31:0]       rx_data_q, rx_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sck_q, sck_d;
    logic [NUM_CS-1:0] cs_q, cs_d;
    logic              pico_q, pico_d;

    logic              cnt_end;
    logic              accept;
    logic              active_d;

    // Keeps the len_q+1 received bytes of the shift register.
    function automatic logic [31:0] len_mask(input logic [1:0] len);
        logic [31:0] m;
        unique case (len)
            2'd0:    m = 32'h0000_00FF;
            2'd1:    m = 32'h0000_FFFF;
            2'd2:    m = 32'h00FF_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        len_d     = len_q;
        cs_sel_d  = cs_sel_q;
        tx_d      = tx_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;

        cnt_end = (cnt_q == CntMax);
        accept  = start_i && (32'(cs_sel_i) < NUM_CS);

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StLead;
                    cnt_d    = '0;
                    tx_d     = tx_data_i;
                    len_d    = len_i;
                    cs_sel_d = cs_sel_i;
                    // Index of the first bit is N-1 = 8*len_i + 7.
                    bit_d    = {len_i, 3'b111};
                    rx_sr_d  = '0;
                end
            end
            StLead: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_end) begin
                    state_d = StLow;
                    cnt_d   = '0;
                end
            end
            StLow: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_end) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end
            end
            StHigh: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_end) begin
                    // The sample point sits as late as possible in the high phase, so a
                    // responder with a synchroniser can still present the bit in time.
                    rx_sr_d = {rx_sr_q[30:0], spi_poci_i};
                    cnt_d   = '0;
                    if (bit_q == 5'd0) begin
                        state_d = StTrail;
                    end else begin
                        state_d = StLow;
                        bit_d   = bit_q - 5'd1;
                    end
                end
            end
            StTrail: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_end) begin
                    state_d   = StGap;
                    cnt_d     = '0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q & len_mask(len_q);
                end
            end
            StGap: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_end) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

`ifdef SPI_CONTROLLER_ABORT_EN
        if (abort_i && (state_q inside {StLead, StLow, StHigh, StTrail})) begin
            state_d   = StGap;
            cnt_d     = '0;
            done_d    = 1'b0;
            rx_data_d = rx_data_q;
        end
`endif

        // Outputs are decoded from the next state, so the flops present the new phase
        // in the same cycle the FSM enters it.
        active_d = state_d inside {StLead, StLow, StHigh, StTrail};
        sck_d    = (state_d == StHigh);
        busy_d   = (state_d != StIdle);
        pico_d   = active_d ? tx_d[bit_d] : 1'b0;
        for (int i = 0; i < NUM_CS; i++) begin
            cs_d[i] = !(active_d && (cs_sel_d == 2'(i)));
        end
    end

    always_ff @(posedge sys_clock_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            len_q     <= '0;
            cs_sel_q  <= '0;
            tx_q      <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sck_q     <= 1'b0;
            cs_q      <= '1;
            pico_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            len_q     <= len_d;
            cs_sel_q  <= cs_sel_d;
            tx_q      <= tx_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sck_q     <= sck_d;
            cs_q      <= cs_d;
            pico_q    <= pico_d;
        end
    end

    assign rx_data_o   = rx_data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign spi_clock_o = sck_q;
    assign spi_cs_o    = cs_q;
    assign spi_pico_o  = pico_q;

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller
//   Testbench for spi_controller. A mode-0 responder model drives POCI and records
//   PICO and the bus timing. Stimulus pushes the expected result of every transfer
//   into a queue, and a monitor pops that queue on each done_o pulse and compares.
//   A second instance with CLK_DIV=6 covers the divider.

module tb_spi_controller;
    localparam int unsigned D   = 4;
    localparam int unsigned D6  = 6;
    localparam int unsigned NCS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst    = 1'b1;
    logic           start  = 1'b0;
    logic [1:0]     cs_sel = 2'd0;
    logic [1:0]     len    = 2'd0;
    logic [31:0]    tx     = 32'd0;
    logic           poci   = 1'b0;
    logic [31:0]    rx_data;
    logic           busy, done, sck, pico;
    logic [NCS-1:0] cs;
`ifdef SPI_CONTROLLER_ABORT_EN
    logic           abort  = 1'b0;
`endif

    logic           start6 = 1'b0;
    logic [31:0]    tx6    = 32'd0;
    logic [31:0]    rx6;
    logic           busy6, done6, sck6, pico6;
    logic [NCS-1:0] cs6;

    spi_controller #(.CLK_DIV(D), .NUM_CS(NCS)) u_dut (
        .sys_clock_i (clk),
        .rst_i       (rst),
        .start_i     (start),
        .cs_sel_i    (cs_sel),
        .len_i       (len),
        .tx_data_i   (tx),
`ifdef SPI_CONTROLLER_ABORT_EN
        .abort_i     (abort),
`endif
        .rx_data_o   (rx_data),
        .busy_o      (busy),
        .done_o      (done),
        .spi_clock_o (sck),
        .spi_cs_o    (cs),
        .spi_pico_o  (pico),
        .spi_poci_i  (poci)
    );

    // PICO is registered, so looping it back to POCI forms no combinational loop.
    spi_controller #(.CLK_DIV(D6), .NUM_CS(NCS)) u_dut6 (
        .sys_clock_i (clk),
        .rst_i       (rst),
        .start_i     (start6),
        .cs_sel_i    (2'd0),
        .len_i       (2'd0),
        .tx_data_i   (tx6),
`ifdef SPI_CONTROLLER_ABORT_EN
        .abort_i     (1'b0),
`endif
        .rx_data_o   (rx6),
        .busy_o      (busy6),
        .done_o      (done6),
        .spi_clock_o (sck6),
        .spi_cs_o    (cs6),
        .spi_pico_o  (pico6),
        .spi_poci_i  (pico6)
    );

    int   cyc         = 0;
    logic rst_at_edge = 1'b1;
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] rx;
        logic [31:0] tx;
        int          sel;
        int          n;
        int          start;
    } exp_t;

    typedef struct {
        logic [31:0] word;
        int          n;
    } resp_t;

    exp_t  exp_q[$];
    resp_t resp_q[$];

    // Cycles from start sample to done for a transfer of len_i = ln.
    function automatic int t_of(input int ln);
        return 1 + D * (2 + 2 * 8 * (ln + 1));
    endfunction

    function automatic logic [31:0] mask_of(input int n);
        return (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    // Responder model and bus observer. Written on falling sys edges only.
    logic [NCS-1:0] cs_at_fall   = '1;
    logic [31:0]    pico_word    = '0;
    int             rise_cnt     = 0;
    int             first_rise   = 0;
    int             cs_bad       = 0;
    int             phase_bad    = 0;
    int             hold_bad     = 0;

    initial begin : responder
        logic        prev_sck    = 1'b0;
        logic        prev_active = 1'b0;
        logic        prev_pico   = 1'b0;
        logic        active;
        logic [31:0] r_word      = '0;
        int          r_idx       = -1;
        int          last_rise   = 0;
        int          hi_run      = 0;
        int          pico_chg    = 0;
        resp_t       r;
        forever begin
            @(negedge clk);
            active = (cs != '1);
            if (active && !prev_active) begin
                cs_at_fall = cs;
                cs_bad     = 0;
                phase_bad  = 0;
                rise_cnt   = 0;
                first_rise = 0;
                pico_word  = '0;
                hi_run     = 0;
                pico_chg   = cyc;
                if (resp_q.size() > 0) begin
                    r      = resp_q.pop_front();
                    r_word = r.word;
                    r_idx  = r.n - 1;
                end else begin
                    r_word = '0;
                    r_idx  = 0;
                end
                poci = r_word[r_idx];
            end else if (active) begin
                if (cs != cs_at_fall) cs_bad++;
                if (pico != prev_pico) begin
                    if (sck) phase_bad++;
                    pico_chg = cyc;
                end
                if (sck && !prev_sck) begin
                    rise_cnt++;
                    if (rise_cnt == 1) first_rise = cyc;
                    else if (cyc - last_rise != 2 * D) phase_bad++;
                    last_rise = cyc;
                    if (cyc - pico_chg < D) phase_bad++;
                    pico_word = {pico_word[30:0], pico};
                end
                if (sck) hi_run++;
                if (!sck && prev_sck) begin
                    if (hi_run != D) phase_bad++;
                    hi_run = 0;
                    r_idx--;
                    if (r_idx >= 0) poci = r_word[r_idx];
                end
            end
            if (!active) poci = 1'b0;
            prev_sck    = sck;
            prev_active = active;
            prev_pico   = pico;
        end
    end

    initial begin : monitor
        exp_t           e;
        logic [31:0]    prev_rx = '0;
        logic [NCS-1:0] pat;
        forever begin
            @(negedge clk);
            if (!done && !rst_at_edge && (rx_data !== prev_rx)) hold_bad++;
            prev_rx = rx_data;
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: done_o high at cycle %0d, required low", cyc);
                end else begin
                    e   = exp_q.pop_front();
                    pat = '1;
                    pat[e.sel] = 1'b0;
                    check("rx_data", rx_data, e.rx);
                    check("done_cycle", cyc, e.start + t_of(e.n / 8 - 1));
                    check("sck_pulses", rise_cnt, e.n);
                    check("pico_bits", pico_word, e.tx);
                    check("first_rise_cycle", first_rise, e.start + 1 + 2 * D);
                    check("cs_pattern", 32'(cs_at_fall), 32'(pat));
                    check("cs_stable", cs_bad, 0);
                    check("sck_pico_timing", phase_bad, 0);
                    check("cs_high_at_done", 32'(cs), 32'(3'b111));
                    check("busy_at_done", 32'(busy), 32'd1);
                end
            end
        end
    end

    // Queue the expected outcome of one transfer whose start is sampled at cycle st.
    task automatic issue(input int sel, input int ln, input logic [31:0] txw,
                         input logic [31:0] resp, input int st);
        exp_t  e;
        resp_t r;
        int    n;
        n       = 8 * (ln + 1);
        r.word  = resp;
        r.n     = n;
        e.rx    = resp & mask_of(n);
        e.tx    = txw & mask_of(n);
        e.sel   = sel;
        e.n     = n;
        e.start = st;
        resp_q.push_back(r);
        exp_q.push_back(e);
    endtask

    task automatic wait_busy_low(input int exp_cyc, input string nm);
        int k = 0;
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: busy_o still high after %0d cycles, required low", nm, k);
        end else begin
            check(nm, cyc, exp_cyc);
        end
    endtask

    task automatic run_xfer(input int sel, input int ln, input logic [31:0] txw,
                            input logic [31:0] resp);
        int c;
        @(negedge clk);
        c = cyc;
        issue(sel, ln, txw, resp, c);
        cs_sel = 2'(sel);
        len    = 2'(ln);
        tx     = txw;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_cycle1", 32'(busy), 32'd1);
        wait_busy_low(c + t_of(ln) + D, "busy_low_cycle");
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        exp_t        e;
        int          c, t1, busy_seen, k, rises, hi, bad6;
        logic        prev6;
        logic [31:0] txr;

        repeat (3) @(negedge clk);
        check("reset_sck", 32'(sck), 32'd0);
        check("reset_cs", 32'(cs), 32'(3'b111));
        check("reset_pico", 32'(pico), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rx", rx_data, 32'd0);
        rst = 1'b0;

        // 1-byte: PICO 0xA5 on CS2, responder returns 0x3C; done at 73, idle at 77.
        run_xfer(2, 0, 32'h0000_00A5, 32'h0000_003C);
        check("rx_after_1byte", rx_data, 32'h0000_003C);
        // 4-byte with the responder echoing the transmit word.
        run_xfer(0, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        check("rx_after_4byte", rx_data, 32'hDEAD_BEEF);

        for (int i = 0; i < 16; i++) begin
            run_xfer(int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), $urandom,
                     $urandom);
        end

        // start held high: second transfer accepted exactly when busy_o first drops.
        t1  = t_of(1);
        txr = $urandom;
        @(negedge clk);
        c = cyc;
        issue(1, 1, txr, 32'h0000_A55A, c);
        issue(1, 1, txr, 32'h0000_1234, c + t1 + D);
        cs_sel = 2'd1;
        len    = 2'd1;
        tx     = txr;
        start  = 1'b1;
        while (cyc < c + t1 + D) @(negedge clk);
        check("b2b_busy_gap", 32'(busy), 32'd0);
        check("b2b_cs_gap", 32'(cs), 32'(3'b111));
        @(negedge clk);
        start = 1'b0;
        check("b2b_second_accept", 32'(busy), 32'd1);
        wait_busy_low(c + 2 * (t1 + D), "b2b_busy_low");

        // A start pulse during the first HIGH phase must not disturb the transfer.
        @(negedge clk);
        c = cyc;
        issue(2, 0, 32'h0000_0096, 32'h0000_00C3, c);
        cs_sel = 2'd2;
        len    = 2'd0;
        tx     = 32'h0000_0096;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 2 + 2 * D) @(negedge clk);
        check("midpulse_in_high", 32'(sck), 32'd1);
        cs_sel = 2'd0;
        len    = 2'd3;
        tx     = $urandom;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_busy_low(c + t_of(0) + D, "midpulse_busy_low");

        // cs_sel_i beyond NUM_CS is never accepted.
        @(negedge clk);
        cs_sel    = 2'd3;
        start     = 1'b1;
        busy_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy || (cs != '1)) busy_seen++;
        end
        start = 1'b0;
        check("sel3_ignored", busy_seen, 0);

        // Reset during the third HIGH phase.
        run_xfer(0, 0, 32'h0000_0012, 32'h0000_0081);
        @(negedge clk);
        c = cyc;
        issue(1, 1, 32'h0000_F00D, 32'h0000_BEEF, c);
        cs_sel = 2'd1;
        len    = 2'd1;
        tx     = 32'h0000_F00D;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 2 + 6 * D) @(negedge clk);
        check("rst_in_high3", 32'(sck), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e = exp_q.pop_back();
        check("rst_mid_sck", 32'(sck), 32'd0);
        check("rst_mid_cs", 32'(cs), 32'(3'b111));
        check("rst_mid_rx", rx_data, 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        repeat (40) @(negedge clk);
        run_xfer(1, 1, $urandom, $urandom);

`ifdef SPI_CONTROLLER_ABORT_EN
        // Abort during bit 5 of a 2-byte transfer keeps the previous receive word.
        run_xfer(0, 0, 32'h0000_0033, 32'h0000_0055);
        @(negedge clk);
        c = cyc;
        issue(2, 1, 32'h0000_5AA5, 32'h0000_FFFF, c);
        cs_sel = 2'd2;
        len    = 2'd1;
        tx     = 32'h0000_5AA5;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 2 + 22 * D) @(negedge clk);
        check("abort_in_high", 32'(sck), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        e = exp_q.pop_back();
        check("abort_cs", 32'(cs), 32'(3'b111));
        check("abort_sck", 32'(sck), 32'd0);
        check("abort_pico", 32'(pico), 32'd0);
        wait_busy_low(c + 2 + 22 * D + D + 1, "abort_busy_low");
        check("abort_rx_kept", rx_data, 32'h0000_0055);
`endif

        // Divider sweep on the CLK_DIV=6 instance (PICO looped to POCI).
        @(negedge clk);
        c      = cyc;
        tx6    = $urandom;
        start6 = 1'b1;
        @(negedge clk);
        start6 = 1'b0;
        rises  = 0;
        hi     = 0;
        bad6   = 0;
        k      = 0;
        prev6  = 1'b0;
        while (!done6 && k < 500) begin
            if (sck6) hi++;
            if (sck6 && !prev6) rises++;
            if (!sck6 && prev6) begin
                if (hi != D6) bad6++;
                hi = 0;
            end
            prev6 = sck6;
            @(negedge clk);
            k++;
        end
        if (!done6) begin
            n_checks++;
            n_fail++;
            $display("FAIL div6_done: no done_o within %0d cycles, required at 109", k);
        end else begin
            check("div6_done_cycle", cyc, c + 1 + D6 * 18);
            check("div6_rx", rx6, {24'd0, tx6[7:0]});
            check("div6_pulses", rises, 8);
            check("div6_half_period", bad6, 0);
        end

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("rx_hold_between_done", hold_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
